// File: rtl/chipset_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : chipset_bus_pkg
// Purpose  : Shared types and helpers for the chipset bus response path.
//            - bus_state_t : response FSM states
//            - OPEN_BUS    : value returned by a read that nobody answered
//            - get_slice() : pull one source's field out of a flattened
//                            per-source vector
// Revision : 1.0 - initial release
// ============================================================================
package chipset_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_DONE    = 2'd2,
    ST_TIMEOUT = 2'd3
  } bus_state_t;

  // Upper bounds for the generic slice helper. Callers zero-pad their
  // flattened vector to SLICE_VEC_W and truncate the result to their width.
  localparam int SLICE_VEC_W = 1024;
  localparam int SLICE_MAX_W = 64;

  // All-ones read data for a cycle closed by the watchdog.
  localparam logic [SLICE_MAX_W-1:0] OPEN_BUS = '1;

  // Field number idx of width bits from a flattened vector. Shift-and-mask
  // keeps the index arithmetic out of bit-select expressions.
  function automatic logic [SLICE_MAX_W-1:0] get_slice(
    input logic [SLICE_VEC_W-1:0] flat,
    input int                     idx,
    input int                     width
  );
    logic [SLICE_VEC_W-1:0] shifted;
    logic [SLICE_MAX_W-1:0] mask;
    shifted = flat >> (idx * width);
    mask    = {SLICE_MAX_W{1'b1}} >> (SLICE_MAX_W - width);
    return shifted[SLICE_MAX_W-1:0] & mask;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bus_priority_encoder.sv
`default_nettype none
// ============================================================================
// Module   : bus_priority_encoder
// Purpose  : Fixed-priority encoder, bit 0 highest priority. Combinational.
// Ports    : request [WIDTH] in  - per-source claims
//            grant   [WIDTH] out - one-hot winner, zero when no claim
//            none            out - no request bit set
// Revision : 1.0 - initial release
// ============================================================================
module bus_priority_encoder
  import chipset_bus_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] request,
  output logic [WIDTH-1:0] grant,
  output logic             none
);

  always_comb begin
    grant = '0;
    none  = 1'b1;
    // Scanning upward, the first set bit wins; 'none' doubles as the
    // "nobody granted yet" flag so later bits are masked off.
    for (int i = 0; i < WIDTH; i++) begin
      if (request[i] && none) begin
        grant[i] = 1'b1;
        none     = 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/bus_response_mux.sv
`default_nettype none
// ============================================================================
// Module   : bus_response_mux
// Purpose  : Steers read data and generates bus_ready for each CPU/DMA bus
//            cycle. Arbitrates NUM_SOURCES internal responders (index 0
//            highest priority) and the external bus, inserts per-source wait
//            states, and closes hung cycles through a watchdog.
// Ports    : clock, reset            - clock, synchronous active-high reset
//            *_read_n / *_write_n    - active-low bus strobes
//            source_select/_data/_ready/_wait_states - per-source interface
//            ext_data, ext_ready     - external bus channel
//            timeout_clear           - clears the sticky timeout flag
//            data_bus_out            - registered read data
//            data_bus_direction      - external bus drives this read
//            bus_ready               - registered cycle-complete
//            active_grant            - registered one-hot grant
//            timeout_error           - sticky watchdog flag
// Revision : 1.0 - initial release
// ============================================================================
module bus_response_mux #(
  parameter int NUM_SOURCES    = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int WAIT_WIDTH     = 4,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TIMEOUT_WIDTH  = 8
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              memory_read_n,
  input  logic                              memory_write_n,
  input  logic                              io_read_n,
  input  logic                              io_write_n,
  input  logic [NUM_SOURCES-1:0]            source_select,
  input  logic [NUM_SOURCES*DATA_WIDTH-1:0] source_data,
  input  logic [NUM_SOURCES-1:0]            source_ready,
  input  logic [NUM_SOURCES*WAIT_WIDTH-1:0] source_wait_states,
  input  logic [DATA_WIDTH-1:0]             ext_data,
  input  logic                              ext_ready,
  input  logic                              timeout_clear,
  output logic [DATA_WIDTH-1:0]             data_bus_out,
  output logic                              data_bus_direction,
  output logic                              bus_ready,
  output logic [NUM_SOURCES-1:0]            active_grant,
  output logic                              timeout_error
);

  import chipset_bus_pkg::*;

  localparam int PAD_DATA = SLICE_VEC_W - NUM_SOURCES * DATA_WIDTH;
  localparam int PAD_WAIT = SLICE_VEC_W - NUM_SOURCES * WAIT_WIDTH;

  // Registered state
  bus_state_t               state_q;
  logic                     strobe_q;
  logic                     read_sample_q;
  logic [NUM_SOURCES-1:0]   grant_q;
  logic                     ext_q;
  logic                     read_q;
  logic [WAIT_WIDTH-1:0]    wait_q;
  logic [TIMEOUT_WIDTH-1:0] wd_q;
  logic [DATA_WIDTH-1:0]    data_q;
  logic                     ready_q;
  logic                     error_q;

  // Combinational helpers
  logic                     strobe_now;
  logic                     read_now;
  logic [NUM_SOURCES-1:0]   enc_grant;
  logic                     enc_none;
  logic [SLICE_VEC_W-1:0]   data_flat;
  logic [SLICE_VEC_W-1:0]   wait_flat;
  logic [WAIT_WIDTH-1:0]    idle_wait;
  logic [DATA_WIDTH-1:0]    grant_data;
  logic                     grant_ready;
  logic                     complete;
  logic [TIMEOUT_WIDTH-1:0] wd_inc;
  logic                     wd_hit;
  logic                     timeout_set;

  assign strobe_now = ~memory_read_n | ~memory_write_n | ~io_read_n | ~io_write_n;
  assign read_now   = ~memory_read_n | ~io_read_n;

  assign data_flat = {{PAD_DATA{1'b0}}, source_data};
  assign wait_flat = {{PAD_WAIT{1'b0}}, source_wait_states};

  bus_priority_encoder #(
    .WIDTH (NUM_SOURCES)
  ) u_priority (
    .request (source_select),
    .grant   (enc_grant),
    .none    (enc_none)
  );

  // Wait-state count of the source that would win if a cycle started now.
  always_comb begin
    idle_wait = '0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      if (enc_grant[i]) begin
        idle_wait = WAIT_WIDTH'(get_slice(wait_flat, i, WAIT_WIDTH));
      end
    end
  end

  // Data and ready of the latched grant; external channel when no source won.
  always_comb begin
    grant_data  = ext_data;
    grant_ready = ext_ready;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      if (grant_q[i]) begin
        grant_data  = DATA_WIDTH'(get_slice(data_flat, i, DATA_WIDTH));
        grant_ready = source_ready[i];
      end
    end
  end

  assign complete = (wait_q == '0) && grant_ready;
  assign wd_inc   = (&wd_q) ? wd_q : wd_q + 1'b1;
  assign wd_hit   = (TIMEOUT_CYCLES != 0) &&
                    (wd_inc == TIMEOUT_WIDTH'(TIMEOUT_CYCLES));

  // A normal completion on the same edge as the watchdog limit takes priority.
  assign timeout_set = (state_q == ST_WAIT) && strobe_q && !complete && wd_hit;

  // The bus strobes are asynchronous to this block, so they are registered
  // once and the FSM acts only on the registered copy.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      strobe_q      <= 1'b0;
      read_sample_q <= 1'b0;
      grant_q       <= '0;
      ext_q         <= 1'b0;
      read_q        <= 1'b0;
      wait_q        <= '0;
      wd_q          <= '0;
      data_q        <= '0;
      ready_q       <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      strobe_q      <= strobe_now;
      read_sample_q <= read_now;
      // Set dominates a simultaneous clear.
      error_q       <= timeout_set | (error_q & ~timeout_clear);

      case (state_q)
        ST_IDLE: begin
          if (strobe_q) begin
            state_q <= ST_WAIT;
            grant_q <= enc_grant;
            ext_q   <= enc_none;
            wait_q  <= enc_none ? '0 : idle_wait;
            wd_q    <= '0;
            read_q  <= read_sample_q;
          end
        end

        ST_WAIT: begin
          if (!strobe_q) begin
            // Aborted cycle: back to idle silently.
            state_q <= ST_IDLE;
            grant_q <= '0;
            ext_q   <= 1'b0;
            read_q  <= 1'b0;
            wait_q  <= '0;
          end else if (complete) begin
            state_q <= ST_DONE;
            ready_q <= 1'b1;
            data_q  <= read_q ? grant_data : '0;
          end else begin
            if (wait_q != '0) begin
              wait_q <= wait_q - 1'b1;
            end
            wd_q <= wd_inc;
            if (wd_hit) begin
              state_q <= ST_TIMEOUT;
              ready_q <= 1'b1;
              data_q  <= read_q ? DATA_WIDTH'(OPEN_BUS) : '0;
            end
          end
        end

        ST_DONE, ST_TIMEOUT: begin
          if (!strobe_q) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b0;
            data_q  <= '0;
            grant_q <= '0;
            ext_q   <= 1'b0;
            read_q  <= 1'b0;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign data_bus_out       = data_q;
  assign bus_ready          = ready_q;
  assign active_grant       = grant_q;
  assign timeout_error      = error_q;
  assign data_bus_direction = ext_q & read_q & (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_bus_response_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_response_mux
// Purpose  : Self-checking bench for bus_response_mux (4 sources, 8-bit data,
//            watchdog limit 8). Directed table, hand-written corner
//            sequences, and random transactions against a transaction-level
//            timing/data model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_response_mux;

  localparam int NS  = 4;
  localparam int DW  = 8;
  localparam int WW  = 4;
  localparam int TMO = 8;

  logic            clock;
  logic            reset;
  logic            memory_read_n, memory_write_n, io_read_n, io_write_n;
  logic [NS-1:0]   source_select;
  logic [NS*DW-1:0] source_data;
  logic [NS-1:0]   source_ready;
  logic [NS*WW-1:0] source_wait_states;
  logic [DW-1:0]   ext_data;
  logic            ext_ready;
  logic            timeout_clear;
  logic [DW-1:0]   data_bus_out;
  logic            data_bus_direction;
  logic            bus_ready;
  logic [NS-1:0]   active_grant;
  logic            timeout_error;

  bus_response_mux #(
    .NUM_SOURCES    (NS),
    .DATA_WIDTH     (DW),
    .WAIT_WIDTH     (WW),
    .TIMEOUT_CYCLES (TMO),
    .TIMEOUT_WIDTH  (8)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .memory_read_n      (memory_read_n),
    .memory_write_n     (memory_write_n),
    .io_read_n          (io_read_n),
    .io_write_n         (io_write_n),
    .source_select      (source_select),
    .source_data        (source_data),
    .source_ready       (source_ready),
    .source_wait_states (source_wait_states),
    .ext_data           (ext_data),
    .ext_ready          (ext_ready),
    .timeout_clear      (timeout_clear),
    .data_bus_out       (data_bus_out),
    .data_bus_direction (data_bus_direction),
    .bus_ready          (bus_ready),
    .active_grant       (active_grant),
    .timeout_error      (timeout_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  typedef struct {
    bit          is_read;
    bit          is_io;
    logic [3:0]  sel;
    logic [15:0] waits;
    int          ready_at;   // granted ready is high before edge n when n >= ready_at
    logic [31:0] sdata;
    logic [7:0]  edata;
    logic [3:0]  exp_grant;
    logic [7:0]  exp_data;
    int          exp_cycle;  // edge (strobe sample = edge 0) after which bus_ready is 1
    bit          exp_timeout;
  } txn_t;

  txn_t tbl[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic txn_t mk(bit rd, bit io, logic [3:0] sel, logic [15:0] w, int ra,
                              logic [31:0] sd, logic [7:0] ed, logic [3:0] eg,
                              logic [7:0] edt, int ec, bit et);
    txn_t t;
    t.is_read = rd; t.is_io = io; t.sel = sel; t.waits = w; t.ready_at = ra;
    t.sdata = sd; t.edata = ed; t.exp_grant = eg; t.exp_data = edt;
    t.exp_cycle = ec; t.exp_timeout = et;
    return t;
  endfunction

  // Reference model: winner is the lowest claiming index; the cycle ends at
  // the later of (wait states + 2) and the ready edge, unless the watchdog
  // forces it first at edge 1 + TMO.
  function automatic txn_t model_fill(input txn_t t);
    txn_t r;
    int g, w, c;
    logic [7:0] d;
    r = t;
    g = -1;
    for (int i = NS - 1; i >= 0; i--) if (t.sel[i]) g = i;
    if (g < 0) begin
      r.exp_grant = 4'b0000;
      w = 0;
      d = t.edata;
    end else begin
      r.exp_grant = 4'(1 << g);
      w = int'(t.waits[g*WW +: WW]);
      d = t.sdata[g*DW +: DW];
    end
    c = (w + 2 > t.ready_at) ? w + 2 : t.ready_at;
    r.exp_timeout = (c > TMO + 1);
    r.exp_cycle   = r.exp_timeout ? TMO + 1 : c;
    r.exp_data    = !t.is_read ? 8'h00 : (r.exp_timeout ? 8'hFF : d);
    return r;
  endfunction

  task automatic drive_strobes(input bit active, input bit rd, input bit io);
    memory_read_n  = !(active &&  rd && !io);
    io_read_n      = !(active &&  rd &&  io);
    memory_write_n = !(active && !rd && !io);
    io_write_n     = !(active && !rd &&  io);
  endtask

  task automatic drive_ready(input logic [3:0] g, input bit val);
    source_ready = 4'($urandom);
    ext_ready    = 1'($urandom);
    if (g == 4'b0000) ext_ready = val;
    else source_ready = (source_ready & ~g) | (val ? g : 4'b0000);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".bus_ready"}, 32'(bus_ready), 32'd0);
    check({tag, ".data"}, 32'(data_bus_out), 32'd0);
    check({tag, ".grant"}, 32'(active_grant), 32'd0);
    check({tag, ".dir"}, 32'(data_bus_direction), 32'd0);
  endtask

  // Runs one full bus cycle starting from IDLE and returns the DUT to IDLE.
  task automatic run_txn(input txn_t t, input bit hold_clear);
    bit done;
    source_select      = t.sel;
    source_wait_states = t.waits;
    source_data        = t.sdata;
    ext_data           = t.edata;
    timeout_clear      = hold_clear;
    drive_strobes(1'b1, t.is_read, t.is_io);
    drive_ready(t.exp_grant, t.ready_at <= 0);
    done = 1'b0;
    for (int n = 0; n <= 20 && !done; n++) begin
      tick();
      check("bus_ready", 32'(bus_ready), 32'(n >= t.exp_cycle));
      check("active_grant", 32'(active_grant), (n >= 1) ? 32'(t.exp_grant) : 32'd0);
      check("direction", 32'(data_bus_direction),
            32'(n >= 1 && t.exp_grant == 4'b0000 && t.is_read));
      if (n == t.exp_cycle) begin
        check("data", 32'(data_bus_out), 32'(t.exp_data));
        check("timeout_error", 32'(timeout_error), 32'(t.exp_timeout));
        done = 1'b1;
      end else begin
        if (n >= 1) source_select = 4'($urandom);  // must not disturb the grant
        drive_ready(t.exp_grant, (n + 1) >= t.ready_at);
      end
    end
    if (!done) check("completion_bound", 32'd0, 32'd1);
    drive_strobes(1'b0, 1'b0, 1'b0);
    tick();
    check("hold.bus_ready", 32'(bus_ready), 32'd1);
    check("hold.data", 32'(data_bus_out), 32'(t.exp_data));
    check("hold.timeout_error", 32'(timeout_error), 32'(t.exp_timeout && !hold_clear));
    timeout_clear = 1'b0;
    tick();
    check_idle("release");
    timeout_clear = 1'b1;
    tick();
    timeout_clear = 1'b0;
    check("cleared.timeout_error", 32'(timeout_error), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, got running, expected done");
    $fatal(1, "global timeout");
  end

  initial begin
    txn_t t;

    // Directed table: inputs plus hand-derived expectations.
    tbl[0] = mk(1, 0, 4'b0010, 16'h0020, 0,  32'h00005A00, 8'h00, 4'b0010, 8'h5A, 4, 0);
    tbl[1] = mk(0, 1, 4'b0101, 16'h0300, 0,  32'h11223344, 8'h00, 4'b0001, 8'h00, 2, 0);
    tbl[2] = mk(1, 1, 4'b0000, 16'hFFFF, 5,  32'h99999999, 8'hC3, 4'b0000, 8'hC3, 5, 0);
    tbl[3] = mk(1, 0, 4'b1000, 16'h1000, 99, 32'h77000000, 8'h00, 4'b1000, 8'hFF, 9, 1);
    tbl[4] = mk(0, 0, 4'b0100, 16'h0700, 0,  32'h12345678, 8'h00, 4'b0100, 8'h00, 9, 0);
    tbl[5] = mk(1, 1, 4'b1100, 16'h0300, 7,  32'h00BE0000, 8'h00, 4'b0100, 8'hBE, 7, 0);
    tbl[6] = mk(1, 0, 4'b0000, 16'h0000, 12, 32'h00000000, 8'h3C, 4'b0000, 8'hFF, 9, 1);

    reset = 1'b1;
    drive_strobes(1'b0, 1'b0, 1'b0);
    source_select = '0; source_data = '0; source_ready = '0;
    source_wait_states = '0; ext_data = '0; ext_ready = 1'b0; timeout_clear = 1'b0;
    repeat (3) tick();
    check_idle("reset");
    check("reset.timeout_error", 32'(timeout_error), 32'd0);
    reset = 1'b0;
    tick();
    check_idle("post_reset");

    for (int i = 0; i < 7; i++) run_txn(tbl[i], 1'b0);

    // Set and clear on the same edge: set wins, clear acts one edge later.
    run_txn(tbl[3], 1'b1);

    // Abort: strobe released after one cycle in WAIT (W1 = 5).
    source_select = 4'b0010; source_wait_states = 16'h0050;
    source_ready = 4'b1111; source_data = 32'h00005A00;
    drive_strobes(1'b1, 1'b1, 1'b0);
    for (int n = 0; n <= 4; n++) begin
      tick();
      check("abort.bus_ready", 32'(bus_ready), 32'd0);
      check("abort.grant", 32'(active_grant), (n == 1 || n == 2) ? 32'd2 : 32'd0);
      if (n == 1) drive_strobes(1'b0, 1'b0, 1'b0);
    end
    check("abort.timeout_error", 32'(timeout_error), 32'd0);
    run_txn(tbl[0], 1'b0);

    // Reset while in DONE with the strobe still low.
    source_select = 4'b0001; source_wait_states = 16'h0000;
    source_ready = 4'b1111; source_data = 32'h000000A7;
    drive_strobes(1'b1, 1'b1, 1'b0);
    repeat (3) tick();
    check("rst_done.bus_ready", 32'(bus_ready), 32'd1);
    check("rst_done.data", 32'(data_bus_out), 32'hA7);
    reset = 1'b1;
    tick();
    check_idle("rst_mid");
    reset = 1'b0;
    tick();
    check("rst_after.grant0", 32'(active_grant), 32'd0);
    tick();
    check("rst_after.grant1", 32'(active_grant), 32'd1);
    tick();
    check("rst_after.bus_ready", 32'(bus_ready), 32'd1);
    check("rst_after.data", 32'(data_bus_out), 32'hA7);
    drive_strobes(1'b0, 1'b0, 1'b0);
    repeat (2) tick();
    check_idle("rst_release");

    // Random transactions against the model.
    for (int k = 0; k < 40; k++) begin
      t.is_read = 1'($urandom);
      t.is_io   = 1'($urandom);
      t.sel     = 4'($urandom);
      for (int s = 0; s < NS; s++)
        t.waits[s*WW +: WW] = 4'(($urandom_range(0, 7) == 0) ? $urandom_range(0, 9)
                                                             : $urandom_range(0, 3));
      t.ready_at = $urandom_range(0, 12);
      t.sdata    = $urandom;
      t.edata    = 8'($urandom);
      t = model_fill(t);
      run_txn(t, ($urandom_range(0, 3) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
